// File: rtl/rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Merges the single-cycle ALU writeback and the long-latency mul/div
// writeback into the single write port of the 2r1w register file. It also
// tracks which registers have a long-latency result still in flight, so
// decode can stall on RAW and WAW hazards.
//
// Ports:
//   clk, reset_n              clock; asynchronous active-low reset
//   alu_val/alu_waddr/wdata   ALU writeback (highest priority, never stalled)
//   mul_val/mul_rdy/...       long-latency writeback with val/rdy handshake
//   issue_val/issue_waddr     decode issuing a long-latency op
//   issue_rdy                 destination has no pending write (no WAW)
//   chk_addr0/chk_addr1       decode source operands under RAW check
//   stall                     a checked source has a pending write
//   rf_wen/rf_waddr/rf_wdata  registered regfile write port
// ---------------------------------------------------------------------------
module rf_writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_val,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              mul_val,
    output logic              mul_rdy,
    input  logic [ADDR_W-1:0] mul_waddr,
    input  logic [DATA_W-1:0] mul_wdata,
    input  logic              issue_val,
    input  logic [ADDR_W-1:0] issue_waddr,
    output logic              issue_rdy,
    input  logic [ADDR_W-1:0] chk_addr0,
    input  logic [ADDR_W-1:0] chk_addr1,
    output logic              stall,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int NREG = 2**ADDR_W;

    // Holding buffer for a mul beat that lost arbitration to the ALU
    logic              r_buf_val;
    logic [ADDR_W-1:0] r_buf_waddr;
    logic [DATA_W-1:0] r_buf_wdata;

    // One bit per register: long-latency write still in flight
    logic [NREG-1:0]   r_pending;

    logic              r_rf_wen;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_mul_rdy;
    logic              w_mul_fire;
    logic              w_issue_rdy;
    logic              w_issue_fire;
    logic              w_commit;
    logic              w_commit_mul;
    logic [ADDR_W-1:0] w_commit_addr;
    logic [DATA_W-1:0] w_commit_data;
    logic              w_buf_fill;
    logic              w_buf_drain;
    logic [NREG-1:0]   w_pending_nxt;

    // Ready depends only on buffer state, so there is no combinational
    // path from mul_val back to mul_rdy.
    assign w_mul_rdy    = !r_buf_val;
    assign w_mul_fire   = mul_val && w_mul_rdy;
    assign w_issue_rdy  = !r_pending[issue_waddr];
    assign w_issue_fire = issue_val && w_issue_rdy && (issue_waddr != '0);

    // A mul beat accepted while the ALU owns the port parks in the buffer.
    // The buffer can never fill and drain in the same cycle because
    // mul_rdy is low whenever it is occupied.
    assign w_buf_fill  = alu_val && w_mul_fire;
    assign w_buf_drain = !alu_val && r_buf_val;

    // Commit selection: ALU, then buffered mul, then mul bypass
    always_comb begin
        w_commit      = 1'b0;
        w_commit_mul  = 1'b0;
        w_commit_addr = '0;
        w_commit_data = '0;
        if (alu_val) begin
            w_commit      = 1'b1;
            w_commit_addr = alu_waddr;
            w_commit_data = alu_wdata;
        end else if (r_buf_val) begin
            w_commit      = 1'b1;
            w_commit_mul  = 1'b1;
            w_commit_addr = r_buf_waddr;
            w_commit_data = r_buf_wdata;
        end else if (w_mul_fire) begin
            w_commit      = 1'b1;
            w_commit_mul  = 1'b1;
            w_commit_addr = mul_waddr;
            w_commit_data = mul_wdata;
        end
    end

    // Scoreboard update: clear is applied first so that a same-cycle set
    // of the same register takes precedence.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_commit_mul) begin
            w_pending_nxt[w_commit_addr] = 1'b0;
        end
        if (w_issue_fire) begin
            w_pending_nxt[issue_waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_val   <= 1'b0;
            r_buf_waddr <= '0;
            r_buf_wdata <= '0;
        end else if (w_buf_fill) begin
            r_buf_val   <= 1'b1;
            r_buf_waddr <= mul_waddr;
            r_buf_wdata <= mul_wdata;
        end else if (w_buf_drain) begin
            r_buf_val   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Writes to x0 are consumed but never reach the regfile
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_wen <= w_commit && (w_commit_addr != '0);
            if (w_commit) begin
                r_rf_waddr <= w_commit_addr;
                r_rf_wdata <= w_commit_data;
            end
        end
    end

    assign mul_rdy   = w_mul_rdy;
    assign issue_rdy = w_issue_rdy;
    assign stall     = ((chk_addr0 != '0) && r_pending[chk_addr0]) ||
                       ((chk_addr1 != '0) && r_pending[chk_addr1]);
    assign rf_wen    = r_rf_wen;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Sits directly upstream of the 2r1w 32x32b register file (x0 reads as zero). Its three outputs drive the regfile write port directly.
- Merges two writeback sources:
  - a single-cycle ALU path, which has priority and no backpressure;
  - a long-latency multiply/divide path with a val/rdy handshake and a 1-entry holding buffer.
- Keeps a per-register pending scoreboard, so decode can stall RAW/WAW hazards against in-flight long-latency results.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width. Number of registers = 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- alu_val  in  1  ALU writeback valid; always accepted.
- alu_waddr  in  ADDR_W  ALU destination register.
- alu_wdata  in  DATA_W  ALU result.
- mul_val  in  1  long-latency writeback valid.
- mul_rdy  out  1  long-latency writeback accepted this cycle.
- mul_waddr  in  ADDR_W  long-latency destination register.
- mul_wdata  in  DATA_W  long-latency result.
- issue_val  in  1  decode issues a long-latency op this cycle.
- issue_waddr  in  ADDR_W  destination of the issued op.
- issue_rdy  out  1  issue allowed, i.e. no WAW hazard.
- chk_addr0  in  ADDR_W  source register 0 under check by decode.
- chk_addr1  in  ADDR_W  source register 1 under check by decode.
- stall  out  1  a checked source has a pending long-latency write.
- rf_wen  out  1  registered write enable to the regfile.
- rf_waddr  out  ADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - rf_wen/rf_waddr/rf_wdata = 0.
  - Holding buffer empty; all pending bits 0.
  - Asserting reset mid-operation discards buffered data and clears the scoreboard immediately, not at the next edge.
- State elements:
  - holding buffer: buf_val, buf_waddr, buf_wdata;
  - pending[2**ADDR_W];
  - output registers.
- mul_rdy = !buf_val. Purely a function of state; no combinational path from mul_val.
- Commit selection each cycle, in priority order:
  - (1) alu_val → commit ALU.
  - (2) else buf_val → commit buffer; the buffer empties.
  - (3) else mul_val && mul_rdy → commit mul directly, a bypass with no buffer cycle.
  - (4) else no commit.
- Buffer fill: alu_val && mul_val && mul_rdy → the mul beat is captured into the buffer, giving buf_val=1 next cycle.
- Latency:
  - Commit in cycle N → rf_wen=1 with matching addr/data in cycle N+1. The regfile write occurs at the end of N+1.
  - No commit → rf_wen=0 next cycle; rf_waddr/rf_wdata hold their old values.
- x0 handling: a commit with waddr=0 produces rf_wen=0 but still counts as consumed (handshake completes, buffer drains).
- Scoreboard:
  - Set pending[issue_waddr] on issue_val && issue_rdy && issue_waddr!=0.
  - Clear pending[addr] when a mul-sourced commit occurs, via buffer or bypass. Clearing happens at commit, not at the regfile write.
  - Set and clear of the same register in the same cycle → set wins.
- issue_rdy = !pending[issue_waddr]. Issue with issue_rdy=0 has no effect.
- stall = (chk_addr0!=0 && pending[chk_addr0]) || (chk_addr1!=0 && pending[chk_addr1]). Combinational from current state; no forwarding of a same-cycle clear.
- Buffer full (buf_val=1) and alu_val=1 → the buffer holds, mul_rdy=0, and the mul source must hold its beat stable.
- Not handled here (decode's responsibility): ALU and mul targeting the same register in flight, since decode stalls this case. No ordering guarantee is given beyond priority.

Test Plan:
- Reset: drive reset_n=0 mid-stream with buf_val=1 and pending[5]=1 → all outputs 0, mul_rdy=1, stall=0 for chk_addr0=5 immediately; no write after release.
- ALU path: alu_val=1, waddr=3, wdata=32'hDEADBEEF → next cycle rf_wen=1, rf_waddr=3, rf_wdata=32'hDEADBEEF. With alu_waddr=0 → rf_wen=0.
- Bypass: mul_val=1 alone, waddr=7, wdata=32'h12345678, with pending[7]=1 → mul_rdy=1; next cycle rf_wen=1, rf_waddr=7; pending[7] cleared; stall deasserts for chk_addr0=7.
- Collision: alu(4, 32'hAAAA5555) and mul(9, 32'h66666666) in the same cycle → cycle+1 writes reg 4 with mul_rdy=0; cycle+2 writes reg 9; mul_rdy returns to 1 in cycle+2.
- Sustained ALU: alu_val=1 for 3 cycles with the buffer full → buffer holds and mul_rdy=0 for all 3 cycles; the buffered value commits in the first cycle with alu_val=0.
- Scoreboard:
  - issue reg 12 → issue_rdy=0 for a second issue to 12; stall=1 for chk_addr1=12.
  - An issue to 0 sets nothing.
  - Issue and mul commit to 12 in the same cycle → pending[12] stays 1.
